// File: rtl/learn_sequencer.sv
// Learn-mode sequencer: walks a song ROM, lights the guide LED for each note,
// sounds the note only on a correct key press and counts hits and misses.
module learn_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [6:0]        keys,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        note_out,
    output logic [6:0]        led_out,
    output logic [7:0]        hits,
    output logic [7:0]        misses,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PROMPT,
        HOLD,
        NEXT,
        FINISH
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [6:0]         keys_prev;
    logic [3:0]         expected;

    logic new_press;
    logic key_match;
    logic code_valid;

    // Rising edge of "any key down"; a key already held is never a fresh press.
    assign new_press  = (keys != 7'd0) && (keys_prev == 7'd0);
    assign key_match  = (keys == led_out);
    assign code_valid = (rom_data != 4'd0) && !rom_data[3];

    function automatic logic [6:0] note_led(input logic [3:0] code);
        return 7'(7'd1 << (code - 4'd1));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            note_out  <= 4'd0;
            led_out   <= 7'd0;
            hits      <= 8'd0;
            misses    <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timer     <= '0;
            keys_prev <= 7'd0;
            expected  <= 4'd0;
        end else begin
            keys_prev <= keys;
            done      <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Mode change: drop everything but keep the session counters.
                state    <= IDLE;
                note_out <= 4'd0;
                led_out  <= 7'd0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            hits     <= 8'd0;
                            misses   <= 8'd0;
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        if (code_valid) begin
                            expected <= rom_data;
                            led_out  <= note_led(rom_data);
                            timer    <= '0;
                            state    <= PROMPT;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                    PROMPT: begin
                        // Timer parks on its last value so a late wrong press still times out.
                        if (timer != TIMER_LAST) begin
                            timer <= timer + TIMER_W'(1);
                        end
                        if (new_press) begin
                            if (key_match) begin
                                if (hits != CNT_MAX) begin
                                    hits <= hits + 8'd1;
                                end
                                note_out <= expected;
                                state    <= HOLD;
                            end else if (misses != CNT_MAX) begin
                                misses <= misses + 8'd1;
                            end
                        end else if (timer == TIMER_LAST) begin
                            if (misses != CNT_MAX) begin
                                misses <= misses + 8'd1;
                            end
                            state <= NEXT;
                        end
                    end
                    HOLD: begin
                        if (keys == 7'd0) begin
                            state <= NEXT;
                        end
                    end
                    NEXT: begin
                        note_out <= 4'd0;
                        led_out  <= 7'd0;
                        if (&rom_addr) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_learn_sequencer.sv
// Bench for learn_sequencer: directed sessions against a cycle-stepped song model.
module tb_learn_sequencer;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    localparam int PH_IDLE   = 0;
    localparam int PH_ROM    = 1;
    localparam int PH_PROMPT = 2;
    localparam int PH_HOLD   = 3;
    localparam int PH_NEXT   = 4;
    localparam int PH_FIN    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [6:0]        keys;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        note_out;
    logic [6:0]        led_out;
    logic [7:0]        hits;
    logic [7:0]        misses;
    logic              busy;
    logic              done;

    logic [3:0] rom_mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    bit note_seen = 1'b0;

    // Song model state
    int m_ph = PH_IDLE;
    int m_lat, m_addr, m_note, m_led, m_hits, m_miss, m_done, m_kprev, m_code;
    longint cyc = 0;
    longint m_deadline = 0;

    learn_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .keys     (keys),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note_out (note_out),
        .led_out  (led_out),
        .hits     (hits),
        .misses   (misses),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the song rules, from the inputs seen at that edge.
    task automatic model_step();
        bit press;
        cyc++;
        if (rst) begin
            m_ph = PH_IDLE; m_addr = 0; m_note = 0; m_led = 0;
            m_hits = 0; m_miss = 0; m_done = 0; m_kprev = 0;
            return;
        end
        press   = (keys != 0) && (m_kprev == 0);
        m_kprev = keys;
        m_done  = 0;
        if (abort && m_ph != PH_IDLE) begin
            m_ph = PH_IDLE; m_note = 0; m_led = 0;
            return;
        end
        case (m_ph)
            PH_IDLE: if (start && !abort) begin
                m_hits = 0; m_miss = 0; m_addr = 0; m_lat = 2; m_ph = PH_ROM;
            end
            PH_ROM: begin
                m_lat--;
                if (m_lat == 0) begin
                    m_code = rom_mem[m_addr];
                    if (m_code >= 1 && m_code <= 7) begin
                        m_led = 1 << (m_code - 1);
                        m_deadline = cyc + TIMEOUT;
                        m_ph = PH_PROMPT;
                    end else begin
                        m_done = 1; m_ph = PH_FIN;
                    end
                end
            end
            PH_PROMPT: begin
                if (press) begin
                    if (keys == m_led) begin
                        if (m_hits < 255) m_hits++;
                        m_note = m_code;
                        m_ph = PH_HOLD;
                    end else if (m_miss < 255) begin
                        m_miss++;
                    end
                end else if (cyc >= m_deadline) begin
                    if (m_miss < 255) m_miss++;
                    m_ph = PH_NEXT;
                end
            end
            PH_HOLD: if (keys == 0) m_ph = PH_NEXT;
            PH_NEXT: begin
                m_note = 0; m_led = 0;
                if (m_addr == DEPTH - 1) begin
                    m_done = 1; m_ph = PH_FIN;
                end else begin
                    m_addr++; m_lat = 2; m_ph = PH_ROM;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    // Compare process: step the model on each edge, check on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (!rst) begin
                check("rom_addr", rom_addr, m_addr);
                check("note_out", note_out, m_note);
                check("led_out",  led_out,  m_led);
                check("hits",     hits,     m_hits);
                check("misses",   misses,   m_miss);
                check("busy",     busy,     (m_ph != PH_IDLE));
                check("done",     done,     m_done);
                if (done) done_cnt++;
                if (note_out != 0) note_seen = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_led(input string name);
        int n = 0;
        while (led_out == 7'd0 && n < 20) begin
            tick(1);
            n++;
        end
        check(name, (led_out != 7'd0), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic load_rom(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c; rom_mem[3] = d;
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; keys = 7'd0;
        load_rom(4'd0, 4'd0, 4'd0, 4'd0);
        tick(2);
        check("rst_note",   note_out, 0);
        check("rst_led",    led_out,  0);
        check("rst_hits",   hits,     0);
        check("rst_misses", misses,   0);
        check("rst_busy",   busy,     0);
        check("rst_done",   done,     0);
        check("rst_addr",   rom_addr, 0);
        #2 rst = 1'b0;
        tick(1);

        // Song 1,3,5 played correctly
        load_rom(4'd1, 4'd3, 4'd5, 4'd0);
        d0 = done_cnt;
        do_start();
        check("t1_led_e0", led_out, 7'h00);
        tick(1);
        check("t1_led_e1", led_out, 7'h00);
        tick(1);
        check("t1_led_e2", led_out, 7'h01);
        keys = 7'h01; tick(1);
        check("t1_note1", note_out, 4'd1);
        keys = 7'h00; tick(2);
        wait_led("t1_wait2");
        check("t1_led2", led_out, 7'h04);
        keys = 7'h04; tick(1);
        check("t1_note3", note_out, 4'd3);
        keys = 7'h00; tick(2);
        wait_led("t1_wait3");
        check("t1_led3", led_out, 7'h10);
        keys = 7'h10; tick(1);
        check("t1_note5", note_out, 4'd5);
        keys = 7'h00;
        wait_idle("t1_idle");
        check("t1_hits",   hits,   8'd3);
        check("t1_misses", misses, 8'd0);
        check("t1_done",   done_cnt - d0, 1);

        // Wrong key then right key
        tick(1);
        load_rom(4'd2, 4'd0, 4'd0, 4'd0);
        do_start();
        wait_led("t2_wait");
        check("t2_led", led_out, 7'h02);
        keys = 7'h01; tick(1);
        check("t2_miss",  misses,   8'd1);
        check("t2_quiet", note_out, 4'd0);
        keys = 7'h00; tick(1);
        keys = 7'h02; tick(1);
        check("t2_note", note_out, 4'd2);
        check("t2_hits", hits,     8'd1);
        keys = 7'h00;
        wait_idle("t2_idle");
        check("t2_misses_end", misses, 8'd1);

        // Timeout with no keys
        tick(1);
        load_rom(4'd4, 4'd0, 4'd0, 4'd0);
        d0 = done_cnt;
        note_seen = 1'b0;
        do_start();
        wait_led("t3_wait");
        tick(7);
        check("t3_not_yet", misses, 8'd0);
        tick(1);
        check("t3_timeout", misses, 8'd1);
        wait_idle("t3_idle");
        check("t3_done",   done_cnt - d0, 1);
        check("t3_silent", note_seen, 0);
        check("t3_hits",   hits, 8'd0);

        // Key held across start is not a press
        tick(1);
        load_rom(4'd1, 4'd0, 4'd0, 4'd0);
        keys = 7'h01; tick(1);
        do_start();
        wait_led("t4_wait");
        tick(2);
        check("t4_held", hits, 8'd0);
        keys = 7'h00; tick(1);
        keys = 7'h01; tick(1);
        check("t4_hit",  hits,     8'd1);
        check("t4_note", note_out, 4'd1);
        keys = 7'h00;
        wait_idle("t4_idle");

        // Full ROM without end marker
        tick(1);
        load_rom(4'd7, 4'd7, 4'd7, 4'd7);
        d0 = done_cnt;
        do_start();
        for (int i = 0; i < 4; i++) begin
            wait_led("t5_wait");
            check("t5_led", led_out, 7'h40);
            keys = 7'h40; tick(1);
            check("t5_note", note_out, 4'd7);
            keys = 7'h00; tick(2);
        end
        wait_idle("t5_idle");
        check("t5_hits", hits,     8'd4);
        check("t5_addr", rom_addr, 2'd3);
        check("t5_done", done_cnt - d0, 1);

        // Abort during HOLD, then abort+start in IDLE, then reset mid-PROMPT
        tick(1);
        load_rom(4'd1, 4'd3, 4'd0, 4'd0);
        d0 = done_cnt;
        do_start();
        wait_led("t6_wait");
        keys = 7'h01; tick(1);
        check("t6_hit", hits, 8'd1);
        abort = 1'b1; tick(1);
        check("t6_ab_busy", busy,     0);
        check("t6_ab_note", note_out, 4'd0);
        check("t6_ab_led",  led_out,  7'd0);
        check("t6_ab_hits", hits,     8'd1);
        abort = 1'b0; keys = 7'h00; tick(1);
        start = 1'b1; abort = 1'b1; tick(1);
        start = 1'b0; abort = 1'b0;
        check("t6_both_busy", busy, 0);
        tick(2);
        check("t6_both_hits", hits, 8'd1);
        check("t6_no_done",   done_cnt - d0, 0);
        do_start();
        wait_led("t6_wait2");
        check("t6_cleared", hits, 8'd0);
        keys = 7'h02; tick(1);
        check("t6_miss", misses, 8'd1);
        keys = 7'h00;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_misses", misses,   8'd0);
        check("t6_rst_led",    led_out,  7'd0);
        check("t6_rst_busy",   busy,     0);
        check("t6_rst_addr",   rom_addr, 0);
        tick(2);
        #2 rst = 1'b0;
        tick(2);
        check("t6_post_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/learn_sequencer.md
# learn_sequencer

Sequencer for learn mode. It walks a song stored in a note ROM and lights the guide LED for each expected note. It waits for the player to press the matching key, and sounds the note only on a correct press. Hits and misses are counted. It sits between the mode controller (start/abort), the debounced key inputs, the song ROM and the buzzer/LED datapath, and drives the same 4-bit note code (0 = silence, 1–7 = do–si) as the free and auto modes.

## Interface
- ADDR_W, 5, song ROM address width; max song length 2^ADDR_W notes
- TIMEOUT, 50_000_000, cycles allowed per prompt before the note counts as missed (≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from mode controller; begins a session
- abort  in  1  level; returns to idle (mode change)
- keys  in  7  key levels, already synchronized/debounced; bit i = note i+1
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  4  ROM note code, valid 1 cycle after rom_addr changes; 0 = end of song
- note_out  out  4  note to sound; 0 = silent
- led_out  out  7  guide LED, one-hot of expected note
- hits  out  8  correct presses, saturating
- misses  out  8  wrong presses + timeouts, saturating
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal song end

## Operation
- Reset: state IDLE; rom_addr, note_out, led_out, hits, misses, timer, keys_prev = 0; busy = done = 0.
- keys_prev registers keys every cycle, in all states. new_press = (keys != 0) && (keys_prev == 0).
- IDLE: note_out = led_out = 0. start → clear hits/misses, rom_addr = 0, go to FETCH. hits/misses otherwise hold their last session value.
- FETCH: one wait cycle for ROM latency → LOAD.
- LOAD: latch expected = rom_data.
  - 0 or 8–15 → FINISH.
  - Otherwise → PROMPT, timer = 0.
- PROMPT: led_out = 1 << (expected−1); timer increments each cycle.
  - new_press with keys == led_out → hits++, note_out = expected, go to HOLD.
  - new_press with any other pattern (wrong key, multiple keys) → misses++, stay, timer not reset.
  - No new_press and timer == TIMEOUT−1 → misses++, go to NEXT, nothing sounded.
- HOLD: led_out and note_out hold while keys != 0. keys == 0 → NEXT.
- NEXT: note_out = led_out = 0.
  - rom_addr == 2^ADDR_W−1 → FINISH.
  - Else rom_addr++, go to FETCH.
- FINISH: done = 1 for this cycle → IDLE.
- Counters saturate at 255; no wrap.

## Timing
- start sampled at edge E0 → FETCH after E0; LOAD after E1; PROMPT with led_out valid after E2.
- Correct new_press sampled at edge En → note_out and hits update after En (1-cycle latency).
- Release sampled at edge Er → NEXT after Er; note_out = 0 after Er+1. Next prompt's led_out after Er+3.
- New press and timeout in the same cycle: the press wins (hit or miss by key value, no timeout miss).
- A key already held when PROMPT is entered is not a press; it must be released and pressed again.
- start while busy: ignored.
- abort (any non-IDLE state): → IDLE next edge; note_out/led_out = 0 after that edge; no done pulse; counters retained.
- abort and start in the same IDLE cycle: abort wins.
- rst mid-session: immediate return to reset values regardless of clock.

## Test plan
- ROM {1,3,5,0}; press keys 0x01, 0x04, 0x10 in turn, each released → note_out 1, 3, 5; hits = 3, misses = 0; done pulses once; led_out = 0x01 exactly 2 cycles after start.
- ROM {2,0}; press 0x01, then 0x02 → misses = 1, hits = 1; note_out stays 0 after the wrong press; note_out = 2 only after the correct press.
- TIMEOUT = 8, ROM {4,0}, no keys → misses = 1 exactly 8 cycles after PROMPT entry; done pulses; note_out never nonzero.
- Hold key 0x01 across start with ROM {1,0} → no hit until release and re-press; then hits = 1.
- ADDR_W = 2, ROM all 7s (no 0 marker), correct presses → 4 hits, done after address 3; rom_addr never wraps past 3.
- abort during HOLD; rst asserted mid-PROMPT → abort gives IDLE next cycle, outputs 0, no done, counters kept; rst immediately clears all outputs and counters.
